// File: rtl/ibex_predict_check.sv
// In-order queue of fetch-side branch predictions, checked against execute-stage resolutions.
// Optional statistics counters are built only when IBEX_PREDICT_STATS_EN is defined.
module ibex_predict_check #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pred_valid_i,
    output logic        pred_ready_o,
    input  logic [31:0] pred_pc_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    input  logic        resolve_valid_i,
    input  logic [31:0] resolve_pc_i,
    input  logic        resolve_taken_i,
    input  logic [31:0] resolve_target_i,
    input  logic        resolve_compressed_i,
    input  logic        flush_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        pc_mismatch_o,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 65;

    logic [AW:0]                count_reg, count_next;
    logic [AW-1:0]              wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]              rd_ptr_reg, rd_ptr_next;
    logic [DEPTH-1:0][EW-1:0]   entry_q;
    logic [EW-1:0]              head;
    logic [31:0]                head_pc, head_target;
    logic                       head_taken;
    logic                       queue_full, queue_empty;
    logic                       resolve_en, pop_en, push_en, mispredict, pc_diff;
    logic [31:0]                fallthrough_pc, correct_pc;
    logic                       redirect_reg;
    logic [31:0]                redirect_pc_reg;
    logic                       mismatch_reg;

    assign queue_full   = (count_reg == (AW+1)'(DEPTH));
    assign queue_empty  = (count_reg == '0);
    assign pred_ready_o = !queue_full;

    assign head        = entry_q[rd_ptr_reg];
    assign head_pc     = head[64:33];
    assign head_taken  = head[32];
    assign head_target = head[31:0];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;
            always_ff @(posedge clk_i) begin
                if (push_en && wr_ptr_reg == AW'(gi)) begin
                    entry_reg <= {pred_pc_i, pred_taken_i, pred_target_i};
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign fallthrough_pc = resolve_pc_i + (resolve_compressed_i ? 32'd2 : 32'd4);
    assign correct_pc     = resolve_taken_i ? resolve_target_i : fallthrough_pc;

    always_comb begin
        resolve_en  = resolve_valid_i && !flush_i;
        pop_en      = resolve_en && !queue_empty;
        mispredict  = 1'b0;
        pc_diff     = 1'b0;
        if (resolve_en) begin
            if (queue_empty) begin
                // Nothing was predicted: fetch assumed fall-through.
                mispredict = resolve_taken_i;
            end else begin
                mispredict = (head_taken != resolve_taken_i) ||
                             (head_taken && resolve_taken_i && head_target != resolve_target_i);
                pc_diff    = (head_pc != resolve_pc_i);
            end
        end
        // A same-cycle push after a mispredict is a wrong-path record.
        push_en = pred_valid_i && !queue_full && !flush_i && !mispredict;

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i || mispredict) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_en) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_next = rd_ptr_reg + 1'b1;
            count_next = count_reg + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
            mismatch_reg    <= 1'b0;
        end else begin
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            redirect_reg <= mispredict;
            if (mispredict) redirect_pc_reg <= correct_pc;
            if (pc_diff)    mismatch_reg    <= 1'b1;
        end
    end

    assign redirect_o    = redirect_reg;
    assign redirect_pc_o = redirect_pc_reg;
    assign pc_mismatch_o = mismatch_reg;

`ifdef IBEX_PREDICT_STATS_EN
    logic [31:0] branches_reg, mispredicts_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branches_reg    <= '0;
            mispredicts_reg <= '0;
        end else begin
            if (resolve_en && branches_reg != 32'hFFFF_FFFF)
                branches_reg <= branches_reg + 32'd1;
            if (mispredict && mispredicts_reg != 32'hFFFF_FFFF)
                mispredicts_reg <= mispredicts_reg + 32'd1;
        end
    end

    assign stat_branches_o    = branches_reg;
    assign stat_mispredicts_o = mispredicts_reg;
`else
    assign stat_branches_o    = 32'd0;
    assign stat_mispredicts_o = 32'd0;
`endif

endmodule
